// File: rtl/apples_pkg.sv
// ============================================================================
// Module : apples_pkg
// Shared types and constants for the multi-apple spawner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apples_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SCAN  = 3'd3,
        ST_FULL  = 3'd4
    } spawn_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois step for taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// Module : lfsr16
// Free-running 16-bit Galois LFSR; a zero seed is replaced by DEFAULT_SEED.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lfsr16
    import apples_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] w_seed;
    logic [15:0] r_q;

    assign w_seed = (seed == 16'h0000) ? DEFAULT_SEED : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= w_seed;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/apple_spawner.sv
// ============================================================================
// Module : apple_spawner
// Multi-slot apple tracker: eat detection, saturating score, LFSR respawn.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apple_spawner
    import apples_pkg::*;
#(
    parameter int          COORD_W    = 4,
    parameter int          NUM_APPLES = 2,
    parameter int          SCORE_W    = 8,
    parameter int          MAX_TRIES  = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            collision,
    input  logic                            head_valid,
    input  logic [COORD_W-1:0]              head_x,
    input  logic [COORD_W-1:0]              head_y,
    output logic [COORD_W-1:0]              occ_x,
    output logic [COORD_W-1:0]              occ_y,
    input  logic                            occ_hit,
    output logic [NUM_APPLES*COORD_W-1:0]   apple_x,
    output logic [NUM_APPLES*COORD_W-1:0]   apple_y,
    output logic [NUM_APPLES-1:0]           apple_valid,
    output logic                            apple_eaten,
    output logic [2:0]                      eaten_idx,
    output logic [SCORE_W-1:0]              score,
    output logic                            board_full
);

    localparam int         CELL_W     = 2 * COORD_W;
    localparam logic [7:0] c_try_last = 8'(MAX_TRIES - 1);

    logic [15:0]                   w_lfsr;
    logic                          w_unused;
    spawn_state_t                  r_state;
    logic [CELL_W-1:0]             r_cand;
    logic [CELL_W-1:0]             r_origin;
    logic [7:0]                    r_tries;
    logic [2:0]                    r_target;
    logic [NUM_APPLES*COORD_W-1:0] r_ax;
    logic [NUM_APPLES*COORD_W-1:0] r_ay;
    logic [NUM_APPLES-1:0]         r_valid;
    logic                          r_eaten;
    logic [2:0]                    r_eidx;
    logic [SCORE_W-1:0]            r_score;

    logic                          w_run;
    logic [COORD_W-1:0]            w_cand_x;
    logic [COORD_W-1:0]            w_cand_y;
    logic [CELL_W-1:0]             w_cand_next;
    logic                          w_eat;
    logic [2:0]                    w_eat_idx;
    logic                          w_clash;
    logic                          w_free_any;
    logic [2:0]                    w_free_idx;
    logic                          w_clean;
    logic                          w_do_eat;
    logic                          w_write;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    assign w_unused    = ^w_lfsr;
    assign w_run       = enable & ~collision;
    // Candidate is held as {y, x} so a plain increment sweeps x first.
    assign w_cand_x    = r_cand[COORD_W-1:0];
    assign w_cand_y    = r_cand[CELL_W-1:COORD_W];
    assign w_cand_next = r_cand + CELL_W'(1);

    always_comb begin
        w_eat      = 1'b0;
        w_eat_idx  = 3'd0;
        w_clash    = 1'b0;
        w_free_any = 1'b0;
        w_free_idx = 3'd0;
        for (int i = 0; i < NUM_APPLES; i++) begin
            if (r_valid[i] && !w_eat &&
                r_ax[i*COORD_W +: COORD_W] == head_x &&
                r_ay[i*COORD_W +: COORD_W] == head_y) begin
                w_eat     = 1'b1;
                w_eat_idx = 3'(i);
            end
            if (r_valid[i] &&
                r_ax[i*COORD_W +: COORD_W] == w_cand_x &&
                r_ay[i*COORD_W +: COORD_W] == w_cand_y) begin
                w_clash = 1'b1;
            end
            if (!r_valid[i] && !w_free_any) begin
                w_free_any = 1'b1;
                w_free_idx = 3'(i);
            end
        end
    end

    assign w_clean  = ~occ_hit & ~w_clash & ~((w_cand_x == head_x) && (w_cand_y == head_y));
    assign w_do_eat = w_run & head_valid & w_eat;
    assign w_write  = w_run & w_clean & ((r_state == ST_CHECK) || (r_state == ST_SCAN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_ax    <= '0;
            r_ay    <= '0;
            r_eaten <= 1'b0;
            r_eidx  <= 3'd0;
            r_score <= '0;
        end else begin
            r_eaten <= 1'b0;
            if (w_do_eat) begin
                r_eaten <= 1'b1;
                r_eidx  <= w_eat_idx;
                if (r_score != '1) begin
                    r_score <= r_score + SCORE_W'(1);
                end
            end
            // The target slot is invalid, so it never collides with an eat.
            for (int i = 0; i < NUM_APPLES; i++) begin
                if (w_do_eat && w_eat_idx == 3'(i)) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_write && r_target == 3'(i)) begin
                    r_valid[i]                  <= 1'b1;
                    r_ax[i*COORD_W +: COORD_W]  <= w_cand_x;
                    r_ay[i*COORD_W +: COORD_W]  <= w_cand_y;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cand   <= '0;
            r_origin <= '0;
            r_tries  <= 8'd0;
            r_target <= 3'd0;
        end else if (w_run) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_free_any) begin
                        r_target <= w_free_idx;
                        r_state  <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    r_cand  <= w_lfsr[CELL_W-1:0];
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_clean) begin
                        r_tries <= 8'd0;
                        r_state <= ST_IDLE;
                    end else if (r_tries < c_try_last) begin
                        r_tries <= r_tries + 8'd1;
                        r_state <= ST_PICK;
                    end else begin
                        r_origin <= r_cand;
                        r_cand   <= w_cand_next;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_clean) begin
                        r_tries <= 8'd0;
                        r_state <= ST_IDLE;
                    end else if (w_cand_next == r_origin) begin
                        r_state <= ST_FULL;
                    end else begin
                        r_cand <= w_cand_next;
                    end
                end
                ST_FULL: begin
                    r_state <= ST_FULL;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign occ_x       = w_cand_x;
    assign occ_y       = w_cand_y;
    assign apple_x     = r_ax;
    assign apple_y     = r_ay;
    assign apple_valid = r_valid;
    assign apple_eaten = r_eaten;
    assign eaten_idx   = r_eidx;
    assign score       = r_score;
    assign board_full  = (r_state == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_apple_spawner.sv
// ============================================================================
// Module : tb_apple_spawner
// Directed self-checking bench for apple_spawner on a 4x4 grid, 2-bit score.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apple_spawner;

    localparam int CW = 2;
    localparam int NA = 2;
    localparam int SW = 2;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic            enable     = 1'b1;
    logic            collision  = 1'b0;
    logic            head_valid = 1'b0;
    logic [CW-1:0]   head_x     = 2'd3;
    logic [CW-1:0]   head_y     = 2'd3;
    logic [CW-1:0]   occ_x;
    logic [CW-1:0]   occ_y;
    logic            occ_hit;
    logic [NA*CW-1:0] apple_x;
    logic [NA*CW-1:0] apple_y;
    logic [NA-1:0]   apple_valid;
    logic            apple_eaten;
    logic [2:0]      eaten_idx;
    logic [SW-1:0]   score;
    logic            board_full;

    logic            full_mode = 1'b0;
    logic            blk_en    = 1'b0;
    logic [CW-1:0]   blk_x     = '0;
    logic [CW-1:0]   blk_y     = '0;

    int total = 0;
    int bad   = 0;

    // Body model: either every cell is occupied or one blocked cell.
    assign occ_hit = full_mode | (blk_en && occ_x == blk_x && occ_y == blk_y);

    apple_spawner #(
        .COORD_W    (CW),
        .NUM_APPLES (NA),
        .SCORE_W    (SW),
        .MAX_TRIES  (8),
        .SEED       (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .collision   (collision),
        .head_valid  (head_valid),
        .head_x      (head_x),
        .head_y      (head_y),
        .occ_x       (occ_x),
        .occ_y       (occ_y),
        .occ_hit     (occ_hit),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .apple_eaten (apple_eaten),
        .eaten_idx   (eaten_idx),
        .score       (score),
        .board_full  (board_full)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [CW-1:0] sx(input int i);
        return apple_x[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] sy(input int i);
        return apple_y[i*CW +: CW];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic eat(input int idx);
        head_x     = sx(idx);
        head_y     = sy(idx);
        head_valid = 1'b1;
        tick(1);
        head_valid = 1'b0;
    endtask

    task automatic wait_valid(input logic [NA-1:0] want, input int lim, output bit ok);
        int k;
        k = 0;
        while (apple_valid !== want && k < lim) begin
            tick(1);
            k++;
        end
        ok = (apple_valid === want);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        total++; if (apple_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", apple_valid); end
        total++; if ({apple_x, apple_y} !== 8'h00) begin bad++; $display("FAIL rst_xy got=%h want=00", {apple_x, apple_y}); end
        total++; if ({apple_eaten, eaten_idx, score, board_full} !== 7'd0) begin bad++; $display("FAIL rst_misc got=%b want=0000000", {apple_eaten, eaten_idx, score, board_full}); end
        #2 rst_n = 1'b1;
        tick(3);
        total++; if (apple_valid !== 2'b01) begin bad++; $display("FAIL fill_slot0_valid got=%b want=01", apple_valid); end
        total++; if ({sx(0), sy(0)} !== 4'h0) begin bad++; $display("FAIL fill_slot0_xy got=%h want=0", {sx(0), sy(0)}); end
        tick(3);
        total++; if (apple_valid !== 2'b11) begin bad++; $display("FAIL fill_valid got=%b want=11", apple_valid); end
        total++; if (apple_x !== 4'b1000 || apple_y !== 4'b1100) begin bad++; $display("FAIL fill_xy got=%b/%b want=1000/1100", apple_x, apple_y); end
        total++; if (score !== 2'd0 || board_full !== 1'b0) begin bad++; $display("FAIL fill_score got=%0d/%b want=0/0", score, board_full); end
    endtask

    task automatic test_eat;
        logic [CW-1:0] ox, oy;
        bit ok;
        ox = sx(1);
        oy = sy(1);
        eat(1);
        total++; if (apple_eaten !== 1'b1 || eaten_idx !== 3'd1) begin bad++; $display("FAIL eat_pulse got=%b/%0d want=1/1", apple_eaten, eaten_idx); end
        total++; if (apple_valid !== 2'b01 || score !== 2'd1) begin bad++; $display("FAIL eat_state got=%b/%0d want=01/1", apple_valid, score); end
        tick(1);
        total++; if (apple_eaten !== 1'b0) begin bad++; $display("FAIL eat_pulse_end got=%b want=0", apple_eaten); end
        tick(1);
        total++; if (apple_valid !== 2'b01) begin bad++; $display("FAIL eat_early_respawn got=%b want=01", apple_valid); end
        wait_valid(2'b11, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL eat_respawn got=%b want=11", apple_valid); end
        total++; if ({sx(1), sy(1)} === {ox, oy} || {sx(1), sy(1)} === {sx(0), sy(0)}) begin bad++; $display("FAIL eat_new_cell got=%h want!=%h,%h", {sx(1), sy(1)}, {ox, oy}, {sx(0), sy(0)}); end
    endtask

    task automatic test_reject;
        bit ok;
        eat(0);
        total++; if (eaten_idx !== 3'd0 || apple_valid !== 2'b10 || score !== 2'd2) begin bad++; $display("FAIL rej_eat got=%0d/%b/%0d want=0/10/2", eaten_idx, apple_valid, score); end
        tick(2);
        blk_x  = occ_x;
        blk_y  = occ_y;
        blk_en = 1'b1;
        tick(1);
        total++; if (apple_valid !== 2'b10) begin bad++; $display("FAIL rej_first_try got=%b want=10", apple_valid); end
        wait_valid(2'b11, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL rej_respawn got=%b want=11", apple_valid); end
        total++; if ({sx(0), sy(0)} === {blk_x, blk_y} || {sx(0), sy(0)} === {sx(1), sy(1)}) begin bad++; $display("FAIL rej_cell got=%h want!=%h,%h", {sx(0), sy(0)}, {blk_x, blk_y}, {sx(1), sy(1)}); end
        blk_en = 1'b0;
    endtask

    task automatic test_freeze;
        logic [NA*CW-1:0] fx, fy;
        fx = apple_x;
        fy = apple_y;
        collision = 1'b1;
        eat(0);
        total++; if (apple_eaten !== 1'b0 || score !== 2'd2 || apple_valid !== 2'b11) begin bad++; $display("FAIL frz_eat got=%b/%0d/%b want=0/2/11", apple_eaten, score, apple_valid); end
        tick(10);
        total++; if (apple_x !== fx || apple_y !== fy || apple_valid !== 2'b11) begin bad++; $display("FAIL frz_hold got=%h/%h/%b want=%h/%h/11", apple_x, apple_y, apple_valid, fx, fy); end
        collision = 1'b0;
        head_x    = 2'd3;
        head_y    = 2'd3;
    endtask

    task automatic test_saturate;
        bit ok;
        for (int n = 0; n < 3; n++) begin
            wait_valid(2'b11, 60, ok);
            total++; if (!ok) begin bad++; $display("FAIL sat_ready%0d got=%b want=11", n, apple_valid); end
            eat(0);
            total++; if (apple_eaten !== 1'b1 || score !== 2'd3) begin bad++; $display("FAIL sat_score%0d got=%b/%0d want=1/3", n, apple_eaten, score); end
        end
        wait_valid(2'b11, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_refill got=%b want=11", apple_valid); end
    endtask

    task automatic test_full;
        int k;
        full_mode = 1'b1;
        eat(1);
        total++; if (apple_eaten !== 1'b1 || eaten_idx !== 3'd1 || apple_valid !== 2'b01) begin bad++; $display("FAIL full_eat got=%b/%0d/%b want=1/1/01", apple_eaten, eaten_idx, apple_valid); end
        tick(10);
        total++; if (board_full !== 1'b0 || apple_valid !== 2'b01) begin bad++; $display("FAIL full_early got=%b/%b want=0/01", board_full, apple_valid); end
        k = 0;
        while (board_full !== 1'b1 && k < 100) begin tick(1); k++; end
        total++; if (board_full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", board_full); end
        total++; if (apple_valid !== 2'b01) begin bad++; $display("FAIL full_slot got=%b want=01", apple_valid); end
        eat(0);
        total++; if (apple_eaten !== 1'b1 || eaten_idx !== 3'd0 || apple_valid !== 2'b00) begin bad++; $display("FAIL full_eat2 got=%b/%0d/%b want=1/0/00", apple_eaten, eaten_idx, apple_valid); end
        tick(10);
        total++; if (apple_valid !== 2'b00 || board_full !== 1'b1 || score !== 2'd3) begin bad++; $display("FAIL full_hold got=%b/%b/%0d want=00/1/3", apple_valid, board_full, score); end
    endtask

    task automatic test_midreset;
        full_mode = 1'b0;
        head_x    = 2'd3;
        head_y    = 2'd3;
        #2 rst_n = 1'b0;
        #1;
        total++; if (board_full !== 1'b0 || score !== 2'd0) begin bad++; $display("FAIL mr_clear1 got=%b/%0d want=0/0", board_full, score); end
        tick(2);
        #2 rst_n = 1'b1;
        tick(6);
        total++; if (apple_valid !== 2'b11 || apple_x !== 4'b1000 || apple_y !== 4'b1100) begin bad++; $display("FAIL mr_fill1 got=%b/%b/%b want=11/1000/1100", apple_valid, apple_x, apple_y); end
        eat(0);
        total++; if (score !== 2'd1 || apple_valid !== 2'b10) begin bad++; $display("FAIL mr_eat got=%0d/%b want=1/10", score, apple_valid); end
        full_mode = 1'b1;
        tick(24);
        total++; if (board_full !== 1'b0 || apple_valid !== 2'b10) begin bad++; $display("FAIL mr_scan got=%b/%b want=0/10", board_full, apple_valid); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (apple_valid !== 2'b00 || {apple_x, apple_y} !== 8'h00) begin bad++; $display("FAIL mr_async_slots got=%b/%h want=00/00", apple_valid, {apple_x, apple_y}); end
        total++; if ({apple_eaten, eaten_idx, score, board_full, occ_x, occ_y} !== 11'd0) begin bad++; $display("FAIL mr_async_misc got=%b want=0", {apple_eaten, eaten_idx, score, board_full, occ_x, occ_y}); end
        full_mode = 1'b0;
        head_x    = 2'd3;
        head_y    = 2'd3;
        tick(2);
        #3 rst_n = 1'b1;
        tick(6);
        total++; if (apple_valid !== 2'b11 || apple_x !== 4'b1000 || apple_y !== 4'b1100) begin bad++; $display("FAIL mr_fill2 got=%b/%b/%b want=11/1000/1100", apple_valid, apple_x, apple_y); end
        total++; if (board_full !== 1'b0 || score !== 2'd0) begin bad++; $display("FAIL mr_after got=%b/%0d want=0/0", board_full, score); end
    endtask

    initial begin
        test_reset;
        test_eat;
        test_reject;
        test_freeze;
        test_saturate;
        test_full;
        test_midreset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
